// File: rtl/dct_transpose_buf.sv
// NxN transpose buffer between the row and column DCT passes.
// Fills row-major, drains column-major, with optional per-block level shift.
module dct_transpose_buf #(
  parameter int DATA_W = 8,
  parameter int N      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              level_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int LW = $clog2(N);
  localparam int AW = 2 * LW;

  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [AW-1:0]     wi_q, wi_d;
  logic [LW-1:0]     rr_q, rr_d;
  logic [LW-1:0]     rc_q, rc_d;
  logic              shift_q, shift_d;
  logic              ov_q, ov_d;
  logic              ol_q, ol_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic [DATA_W-1:0] mem_q [N*N];

  logic              wr_en;
  logic              ld_en;
  logic [DATA_W-1:0] msb;

  assign in_ready  = (state_q == S_FILL) && !rst;
  assign wr_en     = in_valid && in_ready;
  assign msb       = {shift_q, {(DATA_W-1){1'b0}}};
  // Load on entry to DRAIN, then on every handshake except the last.
  assign ld_en     = (state_q == S_DRAIN) &&
                     (!ov_q || (out_ready && !ol_q));

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;
  assign busy      = (state_q == S_DRAIN) || (wi_q != '0);

  always_comb begin
    state_d = state_q;
    wi_d    = wi_q;
    rr_d    = rr_q;
    rc_d    = rc_q;
    shift_d = shift_q;
    ov_d    = ov_q;
    ol_d    = ol_q;
    od_d    = od_q;
    if (wr_en) begin
      wi_d = wi_q + 1'b1;
      if (wi_q == '0)
        shift_d = level_shift;
      if (wi_q == AW'(N*N-1))
        state_d = S_DRAIN;
    end
    if (ld_en) begin
      od_d = mem_q[{rr_q, rc_q}] ^ msb;
      ol_d = (rr_q == LW'(N-1)) &&
             (rc_q == LW'(N-1));
      ov_d = 1'b1;
      rr_d = rr_q + 1'b1;
      if (rr_q == LW'(N-1))
        rc_d = rc_q + 1'b1;
    end else if (ov_q && out_ready && ol_q) begin
      ov_d    = 1'b0;
      ol_d    = 1'b0;
      state_d = S_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      wi_q    <= '0;
      rr_q    <= '0;
      rc_q    <= '0;
      shift_q <= 1'b0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      wi_q    <= wi_d;
      rr_q    <= rr_d;
      rc_q    <= rc_d;
      shift_q <= shift_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
      od_q    <= od_d;
    end
  end

  // Sample storage is never reset; contents are don't-care after rst.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wi_q] <= in_data;
  end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Scoreboard bench for dct_transpose_buf (N=8, DATA_W=8).
// Expected column-major stream is queued when a block is fully driven.
module tb_dct_transpose_buf;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int NN = N * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          level_shift;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int            n_chk = 0;
  int            n_err = 0;
  int            n_pop = 0;
  logic [DW:0]   sb[$];
  logic [DW:0]   e;
  bit            prev_stall = 0;
  logic [DW-1:0] pd;
  logic          pl;
  bit            rnd_ready = 0;
  int            nv, nc, p0;

  always #5 clk = ~clk;

  dct_transpose_buf #(.DATA_W(DW), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .level_shift(level_shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_v", out_valid, 1);
        check("stall_d", out_data, pd);
        check("stall_l", out_last, pl);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_empty", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("out_d", out_data, e[DW-1:0]);
          check("out_l", out_last, e[DW]);
          n_pop++;
        end
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
    end
  end

  task automatic drive_sample(input logic [DW-1:0] d,
                              input logic ls);
    int   t = 0;
    logic acc;
    in_valid    = 1'b1;
    in_data     = d;
    level_shift = ls;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) check("in_tmo", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int base, input bit cst,
                            input bit shift, input bit gaps,
                            input bit tog);
    logic [DW-1:0] s[NN];
    logic          ls;
    for (int k = 0; k < NN; k++) begin
      s[k] = cst ? DW'(base) : DW'(base + k);
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
        check("gap_rdy", in_ready, 1);
        @(posedge clk);
        #1;
      end
      ls = (k == 0) ? shift :
           (tog ? 1'($urandom_range(0, 1)) : shift);
      drive_sample(s[k], ls);
      if (k == 0) check("fill_busy", busy, 1);
    end
    for (int c = 0; c < N; c++)
      for (int r = 0; r < N; r++)
        sb.push_back({(c == N-1 && r == N-1),
                      s[r*N+c] ^ {shift, 7'b0}});
  endtask

  task automatic wait_drain(input bit hold,
                            output int nval, output int ncyc);
    bit done = 0;
    nval = 0;
    ncyc = 0;
    while (!done && ncyc < 3000) begin
      @(negedge clk);
      ncyc++;
      if (hold) check("drain_rdy", in_ready, 0);
      if (out_valid) nval++;
      if (out_valid && out_ready && out_last) begin
        done = 1;
        in_valid = 1'b0;
      end
    end
    if (!done) check("drain_tmo", done, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    level_shift = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov", out_valid, 0);
    check("rst_od", out_data, 0);
    check("rst_ol", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", in_ready, 0);
    rst = 1'b0;
    #1;
    check("rel_rdy", in_ready, 1);
    @(posedge clk);
    #1;

    // Plain ramp at full rate
    send_block(0, 0, 0, 0, 0);
    check("lat0", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat1", out_valid, 1);
    check("first_d", out_data, 0);
    wait_drain(0, nv, nc);
    check("ramp_nval", nv, NN);
    check("ramp_ncyc", nc, NN);
    check("idle_busy", busy, 0);
    check("idle_rdy", in_ready, 1);

    // Level shift with mid-block toggling
    send_block(8'h80, 1, 1, 0, 1);
    wait_drain(0, nv, nc);
    send_block(0, 1, 1, 0, 1);
    wait_drain(0, nv, nc);

    // Random backpressure
    rnd_ready = 1;
    p0 = n_pop;
    send_block(0, 0, 0, 0, 0);
    wait_drain(0, nv, nc);
    check("bp_pops", n_pop - p0, NN);
    rnd_ready = 0;

    // Input gaps, then in_valid held through drain
    send_block(100, 0, 0, 1, 0);
    in_valid = 1'b1;
    in_data = 8'hFF;
    level_shift = 1'b1;
    wait_drain(1, nv, nc);
    send_block(200, 0, 0, 0, 0);
    wait_drain(0, nv, nc);

    // Reset in the middle of a drain
    send_block(0, 0, 0, 0, 0);
    p0 = n_pop;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (n_pop - p0 >= 10) break;
    end
    if (n_pop - p0 < 10) check("rmd_tmo", n_pop - p0, 10);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rmd_ov", out_valid, 0);
    check("rmd_ol", out_last, 0);
    check("rmd_busy", busy, 0);
    check("rmd_rdy0", in_ready, 0);
    sb.delete();
    rst = 1'b0;
    #1;
    check("rmd_rdy1", in_ready, 1);
    @(posedge clk);
    #1;
    send_block(0, 0, 0, 0, 0);
    wait_drain(0, nv, nc);

    // Back-to-back blocks
    send_block(0, 0, 0, 0, 0);
    wait_drain(0, nv, nc);
    check("b2b_rdy", in_ready, 1);
    send_block(64, 0, 0, 0, 0);
    wait_drain(0, nv, nc);

    repeat (3) @(posedge clk);
    #1;
    check("sb_left", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
